md_unit_ctrl: RTL

- Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline; sits in E stage beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from E, holds the HI/LO registers and runs a busy countdown.
- Raises a stall request so D-stage HI/LO-using instructions wait until results commit.

---
 rtl/md_unit_ctrl_pkg.sv | 39 +++
 rtl/md_unit_ctrl_if.sv | 30 +++
 rtl/md_arith.sv | 63 ++++++
 rtl/md_unit_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/md_unit_ctrl_pkg.sv
// md_unit_ctrl_pkg: shared types for the multiply/divide sequencer.
//   md_op_e    : MD operation codes carried with an E-stage MD instruction
//   md_state_e : sequencer states
//   md_res_t   : 64-bit {hi, lo} result payload
package md_unit_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } md_res_t;

  // Operations that occupy the unit for a multi-cycle countdown.
  function automatic logic is_muldiv(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_ctrl_if.sv
// md_unit_ctrl_if: E-stage request / HI-LO result bundle of the MD unit.
//   start, md_op, src_a, src_b : E-stage MD instruction and operands
//   d_md_use                   : D-stage instruction touches HI/LO or the MD unit
//   hi, lo, busy               : registered unit state
//   stall_req                  : combinational request to the hazard unit
// master drives requests (pipeline side), slave is the MD unit.
interface md_unit_ctrl_if;
  import md_unit_ctrl_pkg::*;

  logic              start;
  md_op_e            md_op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              d_md_use;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              busy;
  logic              stall_req;

  modport master (
    output start, md_op, src_a, src_b, d_md_use,
    input  hi, lo, busy, stall_req
  );

  modport slave (
    input  start, md_op, src_a, src_b, d_md_use,
    output hi, lo, busy, stall_req
  );

endinterface

// File: rtl/md_arith.sv
// md_arith: combinational MIPS multiply/divide datapath.
//   op  : MD operation
//   a,b : rs / rt operands
//   res : {hi, lo} result
//   vld : result should be committed (0 on divide by zero or non-arith op)
module md_arith
  import md_unit_ctrl_pkg::*;
(
  input  md_op_e            op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output md_res_t           res,
  output logic              vld
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W-1:0] q_mag;
  logic [DATA_W-1:0] r_mag;

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // instead of hitting an overflow in a native signed divider.
  always_comb begin
    a_neg = a[DATA_W-1];
    b_neg = b[DATA_W-1];
    a_mag = a_neg ? (DATA_W'(0) - a) : a;
    b_mag = b_neg ? (DATA_W'(0) - b) : b;
    q_mag = '0;
    r_mag = '0;
    res   = '0;
    vld   = 1'b1;
    case (op)
      MD_MULT:  res = md_res_t'(PROD_W'(signed'(a)) * PROD_W'(signed'(b)));
      MD_MULTU: res = md_res_t'(PROD_W'(a) * PROD_W'(b));
      MD_DIV: begin
        if (b == '0) begin
          vld = 1'b0;
        end else begin
          q_mag  = a_mag / b_mag;
          r_mag  = a_mag % b_mag;
          res.lo = (a_neg ^ b_neg) ? (DATA_W'(0) - q_mag) : q_mag;
          res.hi = a_neg ? (DATA_W'(0) - r_mag) : r_mag;
        end
      end
      MD_DIVU: begin
        if (b == '0) begin
          vld = 1'b0;
        end else begin
          q_mag  = a / b;
          r_mag  = a % b;
          res.lo = q_mag;
          res.hi = r_mag;
        end
      end
      default: vld = 1'b0;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: E-stage multi-cycle multiply/divide sequencer with HI/LO.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset, aborts any operation in flight
//   bus   : md_unit_ctrl_if.slave (requests in, hi/lo/busy/stall_req out)
// Build option: MD_DIV0_FAST_EN -- a divide by zero completes at once
// (no busy, no stall) instead of running the full DIV_LAT countdown.
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic          clk,
  input  logic          reset,
  md_unit_ctrl_if.slave bus
);

  md_state_e         state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [DATA_W-1:0] hi_q, hi_next;
  logic [DATA_W-1:0] lo_q, lo_next;
  md_res_t           pend, pend_next;
  logic              pend_wr, pend_wr_next;
  logic              busy_q;
  md_res_t           arith_res;
  logic              arith_vld;
  logic              long_op_c;

  md_arith u_arith (
    .op  (bus.md_op),
    .a   (bus.src_a),
    .b   (bus.src_b),
    .res (arith_res),
    .vld (arith_vld)
  );

  // Request that would enter the RUN countdown if accepted.
`ifdef MD_DIV0_FAST_EN
  assign long_op_c = is_muldiv(bus.md_op) && arith_vld;
`else
  assign long_op_c = is_muldiv(bus.md_op);
`endif

  // Next-state, counter, pending result and HI/LO update.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    hi_next      = hi_q;
    lo_next      = lo_q;
    pend_next    = pend;
    pend_wr_next = pend_wr;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (long_op_c) begin
            state_next   = ST_RUN;
            cnt_next     = is_div(bus.md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            pend_next    = arith_res;
            pend_wr_next = arith_vld;
          end else if (bus.md_op == MD_MTHI) begin
            hi_next = bus.src_a;
          end else if (bus.md_op == MD_MTLO) begin
            lo_next = bus.src_a;
          end
        end
      end
      ST_RUN: begin
        // Last busy cycle: commit unless the divide had a zero divisor.
        if (cnt <= CNT_W'(1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          if (pend_wr) begin
            hi_next = pend.hi;
            lo_next = pend.lo;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      hi_q    <= hi_next;
      lo_q    <= lo_next;
      pend    <= pend_next;
      pend_wr <= pend_wr_next;
      busy_q  <= (state_next == ST_RUN);
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = busy_q;
  assign bus.stall_req = bus.d_md_use && (busy_q || (bus.start && long_op_c));

  // The pipeline never issues an MD instruction while the unit is running.
  start_in_run_a: assert property (@(posedge clk) disable iff (reset)
    !((state == ST_RUN) && bus.start && (bus.md_op != MD_NONE)))
    else $error("md_unit_ctrl: MD instruction issued while unit busy");

endmodule
